// File: rtl/sb_stream_xform_pkg.sv
// sb_stream_xform_pkg: shared types and the per-byte transform used by the
// sb_stream_xform pipeline.
//   xf_mode_e    operation selector carried with every beat
//   sb_meta_t    per-beat sideband (dest, last, mode, operand)
//   sb_payload_t full payload at the default data width
//   xform_byte() the per-byte transform, modulo 256
package sb_stream_xform_pkg;

  localparam int DW_DEFAULT = 256;

  typedef enum logic [1:0] {
    XF_PASS = 2'd0,
    XF_ADD  = 2'd1,
    XF_SUB  = 2'd2,
    XF_XOR  = 2'd3
  } xf_mode_e;

  typedef struct packed {
    logic [31:0] dest;
    logic        last;
    xf_mode_e    mode;
    logic [7:0]  operand;
  } sb_meta_t;

  // Bit offsets of the sideband fields inside a packed {data, meta} payload.
  localparam int META_W    = $bits(sb_meta_t);
  localparam int MODE_LSB  = 8;
  localparam int LAST_BIT  = 10;
  localparam int DEST_LSB  = 11;

  typedef struct packed {
    logic [DW_DEFAULT-1:0] data;
    sb_meta_t              meta;
  } sb_payload_t;

  function automatic logic [7:0] xform_byte(xf_mode_e mode, logic [7:0] operand,
                                            logic [7:0] b);
    logic [7:0] r;
    case (mode)
      XF_ADD:  r = b + operand;
      XF_SUB:  r = b - operand;
      XF_XOR:  r = b ^ operand;
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sb_stream_xform_stage.sv
// sb_stream_xform_stage: one valid/ready pipeline slice.
//   up_valid/up_ready/up_payload  upstream handshake and payload
//   dn_valid/dn_ready/dn_payload  downstream handshake and payload
// The slice accepts whenever it is empty or being drained this cycle, so a
// full pipeline still moves one beat per clock and bubbles collapse.
module sb_stream_xform_stage #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [PW-1:0] up_payload,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [PW-1:0] dn_payload
);

  logic          valid_q;
  logic [PW-1:0] payload_q;

  assign up_ready   = !valid_q || dn_ready;
  assign dn_valid   = valid_q;
  assign dn_payload = payload_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q <= 1'b0;
    end else if (up_ready) begin
      valid_q <= up_valid;
    end
  end

  // Payload is don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (up_ready && up_valid) begin
      payload_q <= up_payload;
    end
  end

endmodule

// File: rtl/sb_stream_xform.sv
// sb_stream_xform: pipelined byte-wise transform for SB streams.
//   clk, nreset                      clock, async active-low reset
//   cfg_mode, cfg_operand            operation, sampled with each input beat
//   in_data/dest/last/valid/ready    input SB port
//   out_data/dest/last/valid/ready   output SB port (dest/last unchanged)
//   pkt_count                        saturating count of output last beats
//   done                             sticky: an all-ones input beat was seen
module sb_stream_xform
  import sb_stream_xform_pkg::*;
#(
  parameter int DW     = 256,
  parameter int STAGES = 2,
  parameter int CNTW   = 32
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [1:0]      cfg_mode,
  input  logic [7:0]      cfg_operand,
  input  logic [DW-1:0]   in_data,
  input  logic [31:0]     in_dest,
  input  logic            in_last,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   out_data,
  output logic [31:0]     out_dest,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CNTW-1:0] pkt_count,
  output logic            done
);

  localparam int PW = DW + META_W;

  logic            rst_done;
  logic [STAGES:0] vld;
  logic [STAGES:0] rdy;
  logic [PW-1:0]   pay [STAGES+1];
  sb_meta_t        meta_in;
  logic [DW-1:0]   xf_data;

  assign meta_in = '{dest: in_dest, last: in_last, mode: xf_mode_e'(cfg_mode),
                     operand: cfg_operand};

  // Gating the upstream valid with rst_done keeps stage 0 from loading while
  // in_ready is held low after reset release.
  assign vld[0]      = in_valid && rst_done;
  assign pay[0]      = {in_data, meta_in};
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rst_done && rdy[0];

  // The transform is computed on the way into the final stage so out_data
  // comes straight from a register.
  always_comb begin
    xf_data = '0;
    for (int i = 0; i < DW / 8; i++) begin
      xf_data[8*i +: 8] = xform_byte(xf_mode_e'(pay[STAGES-1][MODE_LSB +: 2]),
                                     pay[STAGES-1][7:0],
                                     pay[STAGES-1][META_W + 8*i +: 8]);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [PW-1:0] stage_in;
    if (k == STAGES - 1) begin : g_last
      assign stage_in = {xf_data, pay[k][META_W-1:0]};
    end else begin : g_mid
      assign stage_in = pay[k];
    end

    sb_stream_xform_stage #(.PW(PW)) u_stage (
      .clk        (clk),
      .nreset     (nreset),
      .up_valid   (vld[k]),
      .up_ready   (rdy[k]),
      .up_payload (stage_in),
      .dn_valid   (vld[k+1]),
      .dn_ready   (rdy[k+1]),
      .dn_payload (pay[k+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign out_data  = pay[STAGES][META_W +: DW];
  assign out_dest  = pay[STAGES][DEST_LSB +: 32];
  assign out_last  = pay[STAGES][LAST_BIT];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pkt_count <= '0;
    end else if (out_valid && out_ready && out_last && !(&pkt_count)) begin
      pkt_count <= pkt_count + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      done <= 1'b0;
    end else if (in_valid && in_ready && (&in_data)) begin
      done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sb_stream_xform.sv
// Scoreboard bench for sb_stream_xform (DW=256, STAGES=2, CNTW=4).
module tb_sb_stream_xform;

  localparam int DW = 256;
  localparam int ST = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic [1:0]    cfg_mode = '0;
  logic [7:0]    cfg_operand = '0;
  logic [DW-1:0] in_data = '0;
  logic [31:0]   in_dest = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [31:0]   out_dest;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] pkt_count;
  logic          done;

  sb_stream_xform #(.DW(DW), .STAGES(ST), .CNTW(CW)) dut (
    .clk(clk), .nreset(nreset), .cfg_mode(cfg_mode), .cfg_operand(cfg_operand),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_dest(out_dest),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .pkt_count(pkt_count), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [31:0]   dest;
    logic          last;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;
  int   ready_mode = 0;
  bit   holding = 0;
  bit   xfer_prev = 0;
  logic [DW-1:0] held;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // 0: out_ready=1, 1: random 50%, 2: held low
  always @(negedge clk) begin
    case (ready_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: at negedge+2 the output handshake for the coming edge is settled.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (xfer_prev) chk("pkt_count", DW'(pkt_count), DW'(exp_cnt));
    xfer_prev = 0;
    if (holding && nreset) begin
      chk("hold_valid", DW'(out_valid), DW'(1));
      chk("hold_data", out_data, held);
    end
    holding = 0;
    if (nreset && out_valid) begin
      if (!out_ready) begin
        holding = 1;
        held = out_data;
      end else if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got %0h want none", out_data);
      end else begin
        e = sbq.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_dest", DW'(out_dest), DW'(e.dest));
        chk("out_last", DW'(out_last), DW'(e.last));
        // Output transfer happens on the coming edge, cyc+1.
        if (e.lat) chk("latency", DW'(cyc + 1 - e.acc), DW'(ST));
        if (e.last && exp_cnt < 15) exp_cnt++;
        xfer_prev = 1;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [31:0] dest,
                      input logic last, input logic [1:0] mode,
                      input logic [7:0] op, input logic [DW-1:0] exp_d,
                      input bit lat);
    int w = 0;
    bit ok = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_dest = dest; in_last = last;
    cfg_mode = mode; cfg_operand = op;
    while (!ok && w < 300) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        #1;
        e.data = exp_d; e.dest = dest; e.last = last; e.acc = cyc; e.lat = lat;
        sbq.push_back(e);
        ok = 1;
      end else begin
        @(negedge clk);
        w++;
      end
    end
    in_valid = 1'b0;
    // Scribble the cfg inputs so in-flight beats prove they ignore them.
    cfg_mode = 2'd3; cfg_operand = 8'hC3;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no in_ready want accept");
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
    end
    repeat (2) @(negedge clk);
    #3;
  endtask

  initial begin
    logic [DW-1:0] d, e;
    bit bp_done;

    // Reset held with in_valid high and all-ones data.
    nreset = 1'b0; in_valid = 1'b1; in_data = '1;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("rst_out_valid", DW'(out_valid), DW'(0));
      chk("rst_pkt_count", DW'(pkt_count), DW'(0));
      chk("rst_done", DW'(done), DW'(0));
      chk("rst_in_ready", DW'(in_ready), DW'(0));
    end
    nreset = 1'b1; in_valid = 1'b0; in_data = '0;
    #1 chk("rel_in_ready_low", DW'(in_ready), DW'(0));
    @(posedge clk);
    #1 chk("rel_in_ready_high", DW'(in_ready), DW'(1));

    // Add mode: byte ramp 0x00..0x1F -> 0x01..0x20, then a wrap beat.
    for (int i = 0; i < 32; i++) begin
      d[8*i +: 8] = 8'(i);
      e[8*i +: 8] = 8'(i + 1);
    end
    send(d, 32'h11, 1'b1, 2'd1, 8'h01, e, 1);
    d = {32{8'h80}}; d[7:0] = 8'hFF;
    e = {32{8'h81}}; e[7:0] = 8'h00;
    send(d, 32'h12, 1'b0, 2'd1, 8'h01, e, 1);
    drain();
    chk("add_pkt_count", DW'(pkt_count), DW'(1));

    // Mode change between back-to-back beats.
    send({32{8'h5A}}, 32'hA, 1'b1, 2'd3, 8'hA5, {32{8'hFF}}, 1);
    send({32{8'h5A}}, 32'hB, 1'b1, 2'd2, 8'h10, {32{8'h4A}}, 1);
    drain();
    chk("mode_pkt_count", DW'(pkt_count), DW'(3));

    // Backpressure: 10 pass beats, random ready then ready held low.
    bp_done = 0;
    fork
      begin
        for (int k = 0; k < 10; k++)
          send({32{8'(k + 8'h30)}}, 32'(k), (k % 3) == 2, 2'd0, 8'h00,
               {32{8'(k + 8'h30)}}, 0);
        bp_done = 1;
      end
    join_none
    ready_mode = 1;
    repeat (6) @(negedge clk);
    ready_mode = 2;
    repeat (20) @(negedge clk);
    #1;
    chk("full_in_ready", DW'(in_ready), DW'(0));
    chk("full_out_valid", DW'(out_valid), DW'(1));
    ready_mode = 0;
    for (int w = 0; w < 400 && !bp_done; w++) @(negedge clk);
    chk("bp_sender_done", DW'(bp_done), DW'(1));
    drain();
    chk("bp_pkt_count", DW'(pkt_count), DW'(6));

    // End-of-test beat: all ones, add 1 -> zeros.
    chk("done_before", DW'(done), DW'(0));
    send('1, 32'hE0F, 1'b0, 2'd1, 8'h01, '0, 1);
    chk("done_accept", DW'(done), DW'(1));
    drain();
    chk("done_sticky", DW'(done), DW'(1));

    // Counter saturation at 15.
    for (int k = 0; k < 16; k++)
      send({32{8'(k)}}, 32'h100 + 32'(k), 1'b1, 2'd0, 8'h00, {32{8'(k)}}, 0);
    drain();
    chk("cnt_at_max", DW'(pkt_count), DW'(15));
    for (int k = 0; k < 2; k++)
      send({32{8'h77}}, 32'h200, 1'b1, 2'd2, 8'h07, {32{8'h70}}, 0);
    drain();
    chk("cnt_saturated", DW'(pkt_count), DW'(15));

    // Reset with two beats in flight.
    ready_mode = 2;
    send({32{8'h33}}, 32'h300, 1'b1, 2'd0, 8'h00, {32{8'h33}}, 0);
    send({32{8'h44}}, 32'h301, 1'b1, 2'd0, 8'h00, {32{8'h44}}, 0);
    @(negedge clk);
    #3;
    nreset = 1'b0;
    sbq.delete();
    holding = 0;
    exp_cnt = 0;
    #1;
    chk("mid_rst_out_valid", DW'(out_valid), DW'(0));
    chk("mid_rst_pkt_count", DW'(pkt_count), DW'(0));
    chk("mid_rst_done", DW'(done), DW'(0));
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    ready_mode = 0;
    repeat (8) begin
      @(negedge clk);
      #3 chk("post_rst_out_valid", DW'(out_valid), DW'(0));
    end
    chk("post_rst_pkt_count", DW'(pkt_count), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
